// File: rtl/status_flag_register_pkg.sv
// Shared definitions for the condition-flag interface.
// Flag packing {N,Z,C,V}, FLAG_MODE codes and the reset flag value.
// Both the flag producer and the condition evaluator import this package,
// so the bit packing is defined in one place only.
package status_flag_register_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] FLAGS_RST = 4'b0000;

  typedef enum logic [1:0] {
    FM_ARITH = 2'b00,
    FM_LOGIC = 2'b01,
    FM_MUL   = 2'b10,
    FM_RSVD  = 2'b11
  } flag_mode_e;

endpackage

// File: rtl/status_flag_register_flag_generator.sv
// flag_generator: combinational next-flag derivation from the ALU result.
// Ports:
//   flag_mode  in  2           ARITH / LOGIC / MUL / reserved
//   alu_res    in  DATA_WIDTH  ALU result (N from MSB, Z over all bits)
//   alu_c      in  1           adder carry-out
//   alu_v      in  1           adder signed overflow
//   shift_c    in  1           barrel-shifter carry-out
//   cur_c      in  1           currently held C
//   cur_v      in  1           currently held V
//   next_flags out 4           {N,Z,C,V}
module flag_generator
  import status_flag_register_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            flag_mode,
  input  logic [DATA_WIDTH-1:0] alu_res,
  input  logic                  alu_c,
  input  logic                  alu_v,
  input  logic                  shift_c,
  input  logic                  cur_c,
  input  logic                  cur_v,
  output logic [3:0]            next_flags
);

  always_comb begin
    next_flags         = '0;
    next_flags[FLAG_N] = alu_res[DATA_WIDTH-1];
    next_flags[FLAG_Z] = (alu_res == '0);
    next_flags[FLAG_C] = cur_c;
    next_flags[FLAG_V] = cur_v;
    case (flag_mode_e'(flag_mode))
      FM_ARITH: begin
        next_flags[FLAG_C] = alu_c;
        next_flags[FLAG_V] = alu_v;
      end
      // Logical ops take C from the shifter; V is architecturally untouched.
      FM_LOGIC: next_flags[FLAG_C] = shift_c;
      // Multiplies only define N and Z.
      FM_MUL:   ;
      default:  ;
    endcase
  end

endmodule

// File: rtl/status_flag_register.sv
// status_flag_register: CPSR flag field {N,Z,C,V} plus one-deep saved copy.
// Optional build macro: STATUS_BYPASS_EN adds the combinational status_fwd
// output so decode can evaluate a condition in the same cycle as the
// flag-setting instruction.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   valid, s_bit      execute-stage instruction valid / requests flag update
//   stall             holds all state (reset excepted)
//   flush             suppresses flag update only
//   flag_mode [1:0]   ARITH/LOGIC/MUL/reserved
//   alu_res, alu_c, alu_v, shift_c   flag sources
//   save, restore     exception entry / return (both = swap)
//   status [3:0]      registered {N,Z,C,V}
//   saved_status [3:0] registered saved copy
//   status_fwd [3:0]  (STATUS_BYPASS_EN only) forwarded flags
module status_flag_register
  import status_flag_register_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  s_bit,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            flag_mode,
  input  logic [DATA_WIDTH-1:0] alu_res,
  input  logic                  alu_c,
  input  logic                  alu_v,
  input  logic                  shift_c,
  input  logic                  save,
  input  logic                  restore,
  output logic [3:0]            status,
  output logic [3:0]            saved_status
`ifdef STATUS_BYPASS_EN
  ,
  output logic [3:0]            status_fwd
`endif
);

  logic [3:0] next_flags;
  logic       upd;

  assign upd = valid & s_bit & ~flush & ~stall & (flag_mode != FM_RSVD);

  flag_generator #(.DATA_WIDTH(DATA_WIDTH)) u_gen (
    .flag_mode  (flag_mode),
    .alu_res    (alu_res),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .shift_c    (shift_c),
    .cur_c      (status[FLAG_C]),
    .cur_v      (status[FLAG_V]),
    .next_flags (next_flags)
  );

  // save reads the pre-edge status, so save+restore naturally swaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      status       <= FLAGS_RST;
      saved_status <= FLAGS_RST;
    end else if (!stall) begin
      if (save)
        saved_status <= status;
      if (restore)
        status <= saved_status;
      else if (upd)
        status <= next_flags;
    end
  end

`ifdef STATUS_BYPASS_EN
  always_comb begin
    status_fwd = status;
    if (restore)
      status_fwd = saved_status;
    else if (upd)
      status_fwd = next_flags;
  end
`endif

endmodule

// File: tb/tb_status_flag_register.sv
module tb_status_flag_register;

  logic        clk = 1'b0;
  logic        rst, valid, s_bit, stall, flush;
  logic [1:0]  flag_mode;
  logic [31:0] alu_res;
  logic        alu_c, alu_v, shift_c, save, restore;
  logic [3:0]  status, saved_status;
`ifdef STATUS_BYPASS_EN
  logic [3:0]  status_fwd;
`endif

  int errors = 0;
  int checks = 0;

  logic [3:0] m_status, m_saved;

  always #5 clk = ~clk;

  status_flag_register #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .s_bit(s_bit), .stall(stall),
    .flush(flush), .flag_mode(flag_mode), .alu_res(alu_res), .alu_c(alu_c),
    .alu_v(alu_v), .shift_c(shift_c), .save(save), .restore(restore),
    .status(status), .saved_status(saved_status)
`ifdef STATUS_BYPASS_EN
    , .status_fwd(status_fwd)
`endif
  );

  // Reference: flags as the architecture defines them, from plain arithmetic.
  function automatic logic [3:0] ref_flags(input logic [1:0] mode, input logic [31:0] res,
                                           input logic c, input logic v, input logic sc,
                                           input logic [3:0] cur);
    logic n, z, nc, nv;
    n  = (res >= 32'h8000_0000);
    z  = (res == 32'd0);
    nc = (mode == 2'd0) ? c : (mode == 2'd1) ? sc : cur[1];
    nv = (mode == 2'd0) ? v : cur[0];
    return {n, z, nc, nv};
  endfunction

  function automatic logic ref_upd();
    return valid && s_bit && !flush && !stall && flag_mode != 2'd3;
  endfunction

  // Advance one clock, updating the reference from the inputs seen at the edge.
  task automatic tick();
    logic [3:0] ns, nsv;
    ns  = m_status;
    nsv = m_saved;
    if (rst) begin
      ns = 4'd0; nsv = 4'd0;
    end else if (!stall) begin
      if (save) nsv = m_status;
      if (restore) ns = m_saved;
      else if (ref_upd()) ns = ref_flags(flag_mode, alu_res, alu_c, alu_v, shift_c, m_status);
    end
    @(posedge clk);
    m_status = ns;
    m_saved  = nsv;
    #1;
  endtask

  task automatic idle();
    rst = 0; valid = 0; s_bit = 0; stall = 0; flush = 0; flag_mode = 2'd0;
    alu_res = 32'd0; alu_c = 0; alu_v = 0; shift_c = 0; save = 0; restore = 0;
  endtask

  task automatic arith(input logic [31:0] res, input logic c, input logic v);
    idle(); valid = 1; s_bit = 1; flag_mode = 2'd0; alu_res = res; alu_c = c; alu_v = v;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst = 1; valid = 1; s_bit = 1; stall = $urandom; flush = $urandom;
      flag_mode = 2'($urandom); alu_res = $urandom; alu_c = 1; alu_v = 1;
      shift_c = 1; save = 1; restore = 1;
      tick();
      checks++;
      if (status !== 4'b0000 || saved_status !== 4'b0000) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b/%b want 0000/0000", i, status, saved_status);
      end
    end
    idle();
  endtask

  task automatic test_arith();
    arith(32'd0, 1, 0);
    tick();
    checks++;
    if (status !== 4'b0110) begin errors++; $display("FAIL arith_zero: got %b want 0110", status); end
    arith(32'h8000_0000, 0, 1);
    tick();
    checks++;
    if (status !== 4'b1001) begin errors++; $display("FAIL arith_neg: got %b want 1001", status); end
  endtask

  task automatic test_logic_mul();
    arith(32'd5, 1, 1);
    tick();
    checks++;
    if (status !== 4'b0011) begin errors++; $display("FAIL setup_0011: got %b want 0011", status); end
    idle(); valid = 1; s_bit = 1; flag_mode = 2'd1; alu_res = 32'd1; shift_c = 0; alu_c = 1;
    tick();
    checks++;
    if (status !== 4'b0001) begin errors++; $display("FAIL logic: got %b want 0001", status); end
    idle(); valid = 1; s_bit = 1; flag_mode = 2'd2; alu_res = 32'd0; alu_c = 1; shift_c = 1;
    tick();
    checks++;
    if (status !== 4'b0101) begin errors++; $display("FAIL mul: got %b want 0101", status); end
  endtask

  task automatic test_blocking();
    for (int k = 0; k < 4; k++) begin
      arith(32'hFFFF_FFFF, 1, 1);
      case (k)
        0: stall = 1;
        1: flush = 1;
        2: s_bit = 0;
        default: flag_mode = 2'd3;
      endcase
      tick();
      checks++;
      if (status !== 4'b0101) begin
        errors++; $display("FAIL block_%0d: got %b want 0101", k, status);
      end
    end
    // Stall must also freeze save/restore.
    idle(); stall = 1; save = 1; restore = 1;
    tick();
    checks++;
    if (status !== 4'b0101 || saved_status !== 4'b0000) begin
      errors++; $display("FAIL stall_save: got %b/%b want 0101/0000", status, saved_status);
    end
    idle();
  endtask

  task automatic test_save_restore();
    arith(32'h8000_0001, 1, 0);
    tick();
    checks++;
    if (status !== 4'b1010) begin errors++; $display("FAIL setup_1010: got %b want 1010", status); end
    arith(32'd0, 0, 0); save = 1;
    tick();
    checks++;
    if (status !== 4'b0100 || saved_status !== 4'b1010) begin
      errors++; $display("FAIL save_upd: got %b/%b want 0100/1010", status, saved_status);
    end
    arith(32'd7, 1, 1); restore = 1; flush = 1;
    tick();
    checks++;
    if (status !== 4'b1010) begin errors++; $display("FAIL restore: got %b want 1010", status); end
    arith(32'd3, 0, 1);
    tick();
    checks++;
    if (status !== 4'b0001) begin errors++; $display("FAIL setup_0001: got %b want 0001", status); end
    idle(); save = 1; restore = 1;
    tick();
    checks++;
    if (status !== 4'b1010 || saved_status !== 4'b0001) begin
      errors++; $display("FAIL swap: got %b/%b want 1010/0001", status, saved_status);
    end
    idle();
  endtask

  task automatic test_random();
    logic [3:0] fwd_exp;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) == 0);
      valid     = ($urandom_range(0, 3) != 0);
      s_bit     = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      flag_mode = 2'($urandom);
      case ($urandom_range(0, 3))
        0: alu_res = 32'd0;
        1: alu_res = 32'h8000_0000;
        default: alu_res = $urandom;
      endcase
      alu_c = $urandom; alu_v = $urandom; shift_c = $urandom;
      save    = ($urandom_range(0, 6) == 0);
      restore = ($urandom_range(0, 6) == 0);
      #1;
`ifdef STATUS_BYPASS_EN
      fwd_exp = restore ? m_saved
              : ref_upd() ? ref_flags(flag_mode, alu_res, alu_c, alu_v, shift_c, m_status)
              : m_status;
      checks++;
      if (status_fwd !== fwd_exp) begin
        errors++; $display("FAIL rand_fwd[%0d]: got %b want %b", i, status_fwd, fwd_exp);
      end
`else
      fwd_exp = 4'd0;
`endif
      tick();
      checks++;
      if (status !== m_status || saved_status !== m_saved) begin
        errors++;
        $display("FAIL rand[%0d]: got %b/%b want %b/%b fwd=%b", i, status, saved_status,
                 m_status, m_saved, fwd_exp);
      end
    end
    idle();
  endtask

`ifdef STATUS_BYPASS_EN
  task automatic test_bypass();
    idle();
    #1;
    checks++;
    if (status_fwd !== m_status) begin errors++; $display("FAIL fwd_idle: got %b want %b", status_fwd, m_status); end
    arith(32'h8000_0000, 1, 1);
    #1;
    checks++;
    if (status_fwd !== 4'b1011) begin errors++; $display("FAIL fwd_upd: got %b want 1011", status_fwd); end
    tick();
    idle();
  endtask
`endif

  // Status may only move when reset, an update, or an unstalled restore
  // was present at the preceding edge.
  logic m_upd_now;
  assign m_upd_now = valid && s_bit && !flush && !stall && flag_mode != 2'd3;
  a_status_cause: assert property (@(posedge clk)
    (status != $past(status)) |-> $past(rst || m_upd_now || (restore && !stall)))
    else $error("FAIL sva status changed without cause");

  initial begin
    m_status = 4'd0;
    m_saved  = 4'd0;
    idle();
    @(negedge clk);
    test_reset();
    test_arith();
    test_logic_mul();
    test_blocking();
    test_save_restore();
`ifdef STATUS_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
